// File: rtl/poci_uart.sv
// APB-style UART: zero-wait-state register slave with a TX FIFO and 8N1 TX/RX engines.
// DATA/STATUS/DIV decoded on paddr[3:2]; bit period is programmable in pclk cycles.
module poci_uart #(
  parameter int DIV_RESET = 208,
  parameter int TX_DEPTH  = 8
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        bus_psel,
  input  logic        bus_penable,
  input  logic        bus_pwrite,
  input  logic [31:0] bus_paddr,
  input  logic [31:0] bus_pwdata,
  output logic [31:0] bus_prdata,
  output logic        bus_pready,
  output logic        bus_pslverr,
  output logic        txd,
  input  logic        rxd
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_DIV, REG_RSVD} reg_e;

  logic          access, wr_en, rd_data;
  reg_e          reg_sel;
  logic [15:0]   div_q, div_d;
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, tx_pop, tx_full, tx_empty, tx_busy;

  state_e        tx_state_q;
  logic [15:0]   tx_cnt_q, tx_div_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q, tx_bit_end;

  state_e        rx_state_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0]   rx_cnt_q, rx_div_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_data_q;
  logic          rx_valid_q, rx_overrun_q;
  logic          rx_half_end, rx_bit_end, rx_done;

  logic unused_bits;
  assign unused_bits = ^{bus_paddr[31:4], bus_paddr[1:0], bus_pwdata[31:16]};

  assign bus_pready  = 1'b1;
  assign bus_pslverr = 1'b0;
  assign txd         = txd_q;

  assign access  = bus_psel & bus_penable;
  assign wr_en   = access & bus_pwrite;
  assign reg_sel = reg_e'(bus_paddr[3:2]);
  assign rd_data = access & ~bus_pwrite & (reg_sel == REG_DATA);

  assign tx_full    = (count_q == FULL_CNT);
  assign tx_empty   = (count_q == '0);
  assign tx_busy    = (tx_state_q != S_IDLE);
  assign push       = wr_en & (reg_sel == REG_DATA) & ~tx_full;
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  // A pop is only possible when idle or at the very end of a stop bit (back-to-back frames).
  assign tx_pop     = ~tx_empty & ((tx_state_q == S_IDLE) | ((tx_state_q == S_STOP) & tx_bit_end));

  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_done     = (rx_state_q == S_STOP) & rx_bit_end & rx_s2_q;

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bus_prdata = '0;
    if (access) begin
      case (reg_sel)
        REG_DATA:   bus_prdata = {24'd0, rx_data_q};
        REG_STATUS: bus_prdata = {27'd0, rx_overrun_q, rx_valid_q, tx_busy, tx_empty, tx_full};
        REG_DIV:    bus_prdata = {16'd0, div_q};
        default:    bus_prdata = '0;
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_en && reg_sel == REG_DIV)
      div_d = (bus_pwdata[15:0] < 16'd4) ? 16'd4 : bus_pwdata[15:0];
    count_d = count_q;
    case ({push, tx_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define its contents.
  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus_pwdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk) begin
    if (reset) begin
      div_q      <= 16'(DIV_RESET);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      txd_q      <= 1'b1;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(DIV_RESET);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      div_q    <= div_d;
      count_q  <= count_d;
      tx_cnt_q <= tx_cnt_q + 16'd1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (tx_pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        tx_state_q <= S_START;
        txd_q      <= 1'b0;
        tx_cnt_q   <= '0;
        tx_div_q   <= div_q;
        tx_shift_q <= fifo_mem[rd_ptr_q];
      end else begin
        case (tx_state_q)
          S_IDLE: txd_q <= 1'b1;
          S_START: if (tx_bit_end) begin
            tx_state_q <= S_DATA;
            txd_q      <= tx_shift_q[0];
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
          end
          S_DATA: if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end
          S_STOP: if (tx_bit_end) tx_state_q <= S_IDLE;
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= 16'(DIV_RESET);
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_cnt_q  <= rx_cnt_q + 16'd1;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= S_START;
          rx_cnt_q   <= '0;
          rx_div_q   <= div_q;
        end
        S_START: if (rx_half_end) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
        end
        S_STOP: if (rx_bit_end) rx_state_q <= S_IDLE;
        default: rx_state_q <= S_IDLE;
      endcase
      if (wr_en && reg_sel == REG_STATUS && bus_pwdata[4]) rx_overrun_q <= 1'b0;
      // A read landing on the completion cycle hands the slot straight to the new byte.
      if (rx_done && (!rx_valid_q || rd_data)) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_done) begin
        rx_overrun_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poci_uart.sv
// Self-checking bench for poci_uart: register vector table, exact TX waveforms built
// from bytes, and RX frames checked against a valid/overrun byte-slot model.
module tb_poci_uart;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, txd;
  logic        rxd = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  bit rec_en = 1'b0;
  bit tx_q[$];
  bit exp_q[$];

  logic        m_valid, m_overrun;
  logic [7:0]  m_data;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[12];

  poci_uart dut (
    .pclk(pclk), .reset(reset),
    .bus_psel(psel), .bus_penable(penable), .bus_pwrite(pwrite),
    .bus_paddr(paddr), .bus_pwdata(pwdata), .bus_prdata(prdata),
    .bus_pready(pready), .bus_pslverr(pslverr),
    .txd(txd), .rxd(rxd)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (rec_en) tx_q.push_back(txd);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge pclk);
    check("prdata_setup_zero", prdata, 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    data = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(name, d, exp);
  endtask

  // Expected line for one 8N1 frame: start, 8 data bits LSB first, stop, each div cycles.
  task automatic add_frame(input logic [7:0] b, input int div);
    for (int p = 0; p < 10; p++) begin
      bit v;
      v = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[3'(p - 1)];
      repeat (div) exp_q.push_back(v);
    end
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic wait_and_check_trace(input string name);
    int bad;
    for (int i = 0; i < 4000 && tx_q.size() < exp_q.size(); i++) @(posedge pclk);
    rec_en = 1'b0;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: txd differs at cycle %0d (got %0d of %0d samples, expected level %0d)",
               name, bad, tx_q.size(), exp_q.size(), exp_q[bad]);
    end
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    @(posedge pclk); #1;
    for (int p = 0; p < 10; p++) begin
      rxd = (p == 0) ? 1'b0 : (p == 9) ? stop : b[3'(p - 1)];
      repeat (div) @(posedge pclk);
      #1;
    end
    rxd = 1'b1;
    repeat (div + 6) @(posedge pclk);
    #1;
  endtask

  function automatic logic [31:0] model_status();
    return {27'd0, m_overrun, m_valid, 1'b0, 1'b1, 1'b0};
  endfunction

  initial begin
    logic [31:0] d;
    int          div, n;
    logic [7:0]  b;
    logic        stop;

    vecs[0]  = '{1'b0, 32'h4, 32'h0000_0002};
    vecs[1]  = '{1'b0, 32'h8, 32'd208};
    vecs[2]  = '{1'b0, 32'hC, 32'h0};
    vecs[3]  = '{1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 32'h8, 32'd2};
    vecs[5]  = '{1'b0, 32'h8, 32'd4};
    vecs[6]  = '{1'b1, 32'h8, 32'hABCD_1234};
    vecs[7]  = '{1'b0, 32'h8, 32'h0000_1234};
    vecs[8]  = '{1'b1, 32'hC, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 32'hC, 32'h0};
    vecs[10] = '{1'b1, 32'h8, 32'd4};
    vecs[11] = '{1'b0, 32'h8, 32'd4};

    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
    check("reset_txd", 32'(txd), 32'd1);
    check("pready", 32'(pready), 32'd1);
    check("pslverr", 32'(pslverr), 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else begin
        apb_read(vecs[i].addr, d);
        check($sformatf("reg_vec_%0d", i), d, vecs[i].data);
      end
    end

    // Setup phase alone must not write DIV.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'd100;
    repeat (3) @(posedge pclk);
    #1 psel = 1'b0;
    read_check("div_setup_only", 32'h8, 32'd4);

    // Single frame 0x55 at div 4: low from N+2, 40-cycle frame.
    apb_write(32'h0, 32'h55);
    rec_en = 1'b1;
    add_idle(1); add_frame(8'h55, 4); add_idle(4);
    read_check("status_busy", 32'h4, 32'h06);
    wait_and_check_trace("tx_frame_55");
    read_check("status_after_frame", 32'h4, 32'h02);

    // Ten writes: nine fit (one popped immediately + eight queued), the tenth is dropped.
    apb_write(32'h0, 32'h00);
    rec_en = 1'b1;
    add_idle(1); add_frame(8'h00, 4);
    for (int k = 1; k < 10; k++) begin
      apb_write(32'h0, 32'(k));
      if (k < 9) add_frame(8'(k), 4);
    end
    read_check("status_full", 32'h4, 32'h05);
    add_idle(8);
    wait_and_check_trace("tx_burst");
    read_check("status_after_burst", 32'h4, 32'h02);

    // Random TX bursts at random divisors.
    for (int it = 0; it < 3; it++) begin
      div = int'($urandom_range(4, 9));
      apb_write(32'h8, 32'(div));
      n = int'($urandom_range(2, 5));
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        apb_write(32'h0, {24'd0, b});
        if (k == 0) begin
          rec_en = 1'b1;
          add_idle(1);
        end
        add_frame(b, div);
      end
      add_idle(4);
      wait_and_check_trace($sformatf("tx_random_%0d", it));
    end

    // RX single frame.
    apb_write(32'h8, 32'd4);
    m_valid = 1'b0; m_overrun = 1'b0; m_data = 8'h00;
    send_rx(8'hA3, 4, 1'b1);
    read_check("rx_status_valid", 32'h4, 32'h0A);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    repeat (3) @(posedge pclk);
    #1 psel = 1'b0;
    read_check("rx_valid_kept_setup", 32'h4, 32'h0A);
    read_check("rx_data_a3", 32'h0, 32'hA3);
    read_check("rx_valid_cleared", 32'h4, 32'h02);

    // Overrun: second byte dropped, first kept; RX bits 0x18 alongside tx_empty.
    send_rx(8'h11, 4, 1'b1);
    send_rx(8'h22, 4, 1'b1);
    read_check("rx_overrun_status", 32'h4, 32'h1A);
    read_check("rx_overrun_data", 32'h0, 32'h11);
    read_check("rx_overrun_sticky", 32'h4, 32'h12);
    apb_write(32'h4, 32'h10);
    read_check("rx_overrun_clear", 32'h4, 32'h02);

    // Random RX frames, some with framing errors, against the byte-slot model.
    for (int it = 0; it < 8; it++) begin
      div = int'($urandom_range(4, 9));
      apb_write(32'h8, 32'(div));
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_rx(b, div, stop);
      if (stop) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data = b;
        end else m_overrun = 1'b1;
      end
      read_check($sformatf("rx_rand_status_%0d", it), 32'h4, model_status());
      if (m_valid && $urandom_range(0, 1) == 1) begin
        read_check($sformatf("rx_rand_data_%0d", it), 32'h0, {24'd0, m_data});
        m_valid = 1'b0;
      end
      if (m_overrun && $urandom_range(0, 1) == 1) begin
        apb_write(32'h4, 32'h10);
        m_overrun = 1'b0;
      end
    end
    if (m_valid) read_check("rx_rand_drain", 32'h0, {24'd0, m_data});

    // Glitch on rxd, then reset in the middle of a TX frame.
    apb_write(32'h8, 32'd4);
    @(posedge pclk); #1 rxd = 1'b0;
    @(posedge pclk); #1 rxd = 1'b1;
    repeat (8) @(posedge pclk);
    #1;
    read_check("rx_glitch_ignored", 32'h4, 32'h02);
    apb_write(32'h0, 32'hF0);
    repeat (10) @(posedge pclk);
    #1;
    check("txd_midframe_low", 32'(txd), 32'd0);
    reset = 1'b1;
    @(posedge pclk); #1;
    check("txd_after_reset", 32'(txd), 32'd1);
    reset = 1'b0;
    read_check("status_after_reset", 32'h4, 32'h02);
    read_check("div_after_reset", 32'h8, 32'd208);
    repeat (5) @(posedge pclk);
    #1;
    check("txd_idle_after_reset", 32'(txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
